// File: rtl/conv1_window_gen.sv
// Streaming KxK sliding-window generator feeding conv1: K-1 line buffers plus a shifting window register.
// Optional define CONV1_WINGEN_IDX_EN adds win_row/win_col output-map coordinates.
module conv1_window_gen #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int K     = 5,
   parameter int DW    = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [DW-1:0]        pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic [K*K*DW-1:0]    input_act,
   output logic                 valid,
   output logic                 busy,
   output logic                 frame_done
`ifdef CONV1_WINGEN_IDX_EN
   ,
   output logic [$clog2(IMG_H)-1:0] win_row,
   output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                       state_q;
   logic [CW-1:0]                col_q;
   logic [RW-1:0]                row_q;
   logic [K-1:0][K-1:0][DW-1:0]  win_q, win_d;
   logic [K-1:0][DW-1:0]         newcol;
   logic                         valid_q, done_q, busy_q;
   logic [DW-1:0]                lb_q [K-1][IMG_W];
   logic                         acc, col_last, row_last, win_ok;

   assign acc       = pix_valid && (state_q == S_RUN);
   assign col_last  = (col_q == CW'(IMG_W-1));
   assign row_last  = (row_q == RW'(IMG_H-1));
   assign win_ok    = (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));

   assign pix_ready  = (state_q == S_RUN);
   assign input_act  = win_q;
   assign valid      = valid_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   // Incoming column: buffered rows at this column, oldest on top, new pixel at the bottom.
   always_comb begin
      newcol = '0;
      for (int r = 0; r < K-1; r++) newcol[r] = lb_q[r][col_q];
      newcol[K-1] = pix_in;
   end

   always_comb begin
      win_d = win_q;
      if (acc) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][K-1] = newcol[r];
         end
      end
   end

   // Line buffer RAM carries no reset; stale rows are flushed before any window is flagged.
   always_ff @(posedge clk) begin
      if (acc) begin
         for (int r = 0; r < K-1; r++) lb_q[r][col_q] <= newcol[r+1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         win_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= acc && win_ok;
         done_q  <= acc && row_last && col_last;
         win_q   <= win_d;
         case (state_q)
            S_IDLE: if (start) begin
               state_q <= S_RUN;
               busy_q  <= 1'b1;
               col_q   <= '0;
               row_q   <= '0;
            end
            S_RUN: if (acc) begin
               if (col_last) begin
                  col_q <= '0;
                  if (row_last) begin
                     row_q   <= '0;
                     state_q <= S_DONE;
                  end else begin
                     row_q <= row_q + 1'b1;
                  end
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CONV1_WINGEN_IDX_EN
   logic [RW-1:0] win_row_q;
   logic [CW-1:0] win_col_q;

   assign win_row = win_row_q;
   assign win_col = win_col_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (acc && win_ok) begin
         win_row_q <= row_q - RW'(K-1);
         win_col_q <= col_q - CW'(K-1);
      end
   end
`endif

endmodule

// File: tb/tb_conv1_window_gen.sv
// Randomized bench for conv1_window_gen: frame image model, windows rebuilt from the image by coordinates.
module tb_conv1_window_gen;
   localparam int W  = 32;
   localparam int H  = 32;
   localparam int K  = 5;
   localparam int DW = 16;
   localparam int AW = K*K*DW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic [AW-1:0] input_act;
   logic          valid, busy, frame_done;
`ifdef CONV1_WINGEN_IDX_EN
   logic [4:0]    win_row, win_col;
`endif

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] img [H][W];
   logic [AW-1:0] ref_q [$];

   always #5 clk = ~clk;

   conv1_window_gen #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .input_act(input_act), .valid(valid), .busy(busy),
      .frame_done(frame_done)
`ifdef CONV1_WINGEN_IDX_EN
      , .win_row(win_row), .win_col(win_col)
`endif
   );

   task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Window whose bottom-right pixel is (r,c), built straight from the frame image.
   function automatic logic [AW-1:0] model_win(input int r, input int c);
      logic [AW-1:0] w = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            w[(i*K+j)*DW +: DW] = img[r-K+1+i][c-K+1+j];
      return w;
   endfunction

   function automatic logic [DW-1:0] el(input logic [AW-1:0] v, input int idx);
      return v[idx*DW +: DW];
   endfunction

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_ready"}, pix_ready, 0);
      chk({tag, "_act"}, input_act, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, frame_done, 0);
`ifdef CONV1_WINGEN_IDX_EN
      chk({tag, "_wrow"}, win_row, 0);
      chk({tag, "_wcol"}, win_col, 0);
`endif
   endtask

   // Runs one frame from IDLE up to stop_at accepted pixels; called and returns at a negedge.
   task automatic run_frame(input int duty, input bit rnd_pix, input int stop_at,
                            input bit mid_start, input bit save_ref, input bit cmp_ref);
      int n = 0, cyc = 0, nwin = 0, pr = 0, pc = 0;
      bit pacc = 0, expv;
      logic [AW-1:0] r;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = rnd_pix ? DW'($urandom) : DW'(y*W + x);
      pix_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("run_busy", busy, 1);
      while (1) begin
         expv = pacc && pr >= K-1 && pc >= K-1;
         chk("valid", valid, expv);
         chk("frame_done", frame_done, pacc && pr == H-1 && pc == W-1);
         if (expv) begin
            chk("window", input_act, model_win(pr, pc));
`ifdef CONV1_WINGEN_IDX_EN
            chk("win_row", win_row, pr-K+1);
            chk("win_col", win_col, pc-K+1);
`endif
            if (!rnd_pix && nwin == 0) begin
               chk("first_00", el(input_act, 0), 0);
               chk("first_04", el(input_act, 4), 4);
               chk("first_40", el(input_act, 20), 128);
               chk("first_44", el(input_act, 24), 132);
            end
            if (!rnd_pix && pr == 5 && pc == 4) begin
               chk("rowb_00", el(input_act, 0), 32);
               chk("rowb_44", el(input_act, 24), 164);
            end
            if (save_ref) ref_q.push_back(input_act);
            if (cmp_ref) begin
               r = (ref_q.size() > 0) ? ref_q.pop_front() : '0;
               chk("vs_b2b", input_act, r);
            end
            nwin++;
         end
         if (n == stop_at) break;
         chk("ready_run", pix_ready, 1);
         if (cyc > 20000) begin
            chk("timeout", n, stop_at);
            break;
         end
         pix_valid = ($urandom_range(99) < duty);
         pix_in = img[n / W][n % W];
         start = mid_start && (n == 300);
         @(posedge clk);
         pacc = pix_valid;
         pr = n / W;
         pc = n % W;
         if (pacc) n++;
         @(negedge clk);
         cyc++;
      end
      pix_valid = 1'b0;
      start = 1'b0;
      if (stop_at == W*H) begin
         chk("nwin", nwin, (W-K+1)*(H-K+1));
         chk("done_busy", busy, 1);
         chk("done_ready", pix_ready, 0);
         start = 1'b1;               // arrives in DONE: must be ignored
         @(negedge clk);
         start = 1'b0;
         chk("idle_busy", busy, 0);
         chk("idle_done", frame_done, 0);
         chk("idle_ready", pix_ready, 0);
         pix_valid = 1'b1;           // not consumed while IDLE
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_pv_ready", pix_ready, 0);
            chk("idle_pv_valid", valid, 0);
            chk("idle_pv_busy", busy, 0);
         end
         pix_valid = 1'b0;
      end
   endtask

   initial begin
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rstn = 1'b1;
      @(negedge clk);
      chk("post_reset_busy", busy, 0);

      run_frame(100, 0, W*H, 0, 1, 0);   // ramp, back-to-back
      run_frame(50,  0, W*H, 1, 0, 1);   // ramp, bubbles + mid-frame start
      run_frame(60,  1, W*H, 0, 0, 0);   // random pixels, bubbles
      run_frame(100, 0, 500, 0, 0, 0);   // partial frame then reset
      rstn = 1'b0;
      @(negedge clk);
      check_zero_outputs("midreset");
      rstn = 1'b1;
      @(negedge clk);
      run_frame(100, 0, W*H, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
